// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and encodings for the multi-cycle RV32I controller
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMREAD,
    ST_MEMWB,
    ST_MEMWRITE,
    ST_EXECR,
    ST_EXECI,
    ST_ALUWB,
    ST_BEQ,
    ST_JAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // States that hold on the memory handshake and feed the timeout counter
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_imm_decoder.sv
// rtl/mc_imm_decoder.sv - opcode to immediate-format select for the extend unit
module mc_imm_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);

  // R-type has no immediate; it shares the I encoding as a don't-care
  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I sequencing FSM with memory handshake and timeout
// Optional performance counters under MC_CTRL_PERF_EN.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_valid,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_op,
  output logic       mem_timeout
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);

  localparam int             TO_W     = $clog2(MEM_TIMEOUT + 2);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t          state;
  state_t          state_next;
  logic [1:0]      imm_dec;
  logic [TO_W-1:0] to_cnt;
  logic            waiting;

  mc_imm_decoder u_imm_dec (
    .opcode  (opcode),
    .imm_src (imm_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:  state_next = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = ST_MEMADR;
          OP_RTYPE:          state_next = ST_EXECR;
          OP_ITYPE:          state_next = ST_EXECI;
          OP_BRANCH:         state_next = ST_BEQ;
          OP_JAL:            state_next = ST_JAL;
          default:           state_next = ST_FETCH;
        endcase
      end
      ST_MEMADR:   state_next = (opcode == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD:  if (mem_ready) state_next = ST_MEMWB;
      ST_MEMWB:    state_next = ST_FETCH;
      ST_MEMWRITE: if (mem_ready) state_next = ST_FETCH;
      ST_EXECR:    state_next = ST_ALUWB;
      ST_EXECI:    state_next = ST_ALUWB;
      ST_ALUWB:    state_next = ST_FETCH;
      ST_BEQ:      state_next = ST_FETCH;
      ST_JAL:      state_next = ST_ALUWB;
      default:     state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_valid  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    imm_src    = IMM_I;
    illegal_op = 1'b0;
    if (state != ST_RESET) imm_src = imm_dec;
    case (state)
      ST_FETCH: begin
        mem_valid  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      ST_DECODE: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        illegal_op = (state_next == ST_FETCH);
      end
      ST_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMREAD: begin
        mem_valid = 1'b1;
        adr_src   = 1'b1;
      end
      ST_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      ST_MEMWRITE: begin
        mem_valid = 1'b1;
        adr_src   = 1'b1;
        mem_write = mem_ready;
      end
      ST_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
      end
      ST_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      ST_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = zero;
      end
      ST_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

  // Any cycle that is not a stalled access clears the count, so each access starts from zero
  assign waiting = is_mem_wait_state(state) && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      mem_timeout <= 1'b0;
    end else if (waiting) begin
      if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + TO_W'(1);
      if ((MEM_TIMEOUT != 0) && (to_cnt == TO_LIMIT - TO_W'(1))) mem_timeout <= 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic retire;

  assign retire = (state_next == ST_FETCH) &&
                  ((state == ST_MEMWB) || (state == ST_MEMWRITE) ||
                   (state == ST_ALUWB) || (state == ST_BEQ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (state != ST_RESET) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - instruction-level reference model bench for multicycle_controller
module tb_multicycle_controller;

  localparam int TO = 4;
  localparam int CW = 16;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum int {S_RST, S_F, S_D, S_MA, S_MR, S_MWB, S_MW, S_XR, S_XI, S_AWB, S_BEQ, S_JAL} step_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_next = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_valid, adr_src, ir_write, pc_write, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic       illegal_op, mem_timeout;
`ifdef MC_CTRL_PERF_EN
  logic [CW-1:0] retired_cnt, cycle_cnt;
`endif

  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_valid   (mem_valid),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .imm_src     (imm_src),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout)
`ifdef MC_CTRL_PERF_EN
    ,
    .retired_cnt (retired_cnt),
    .cycle_cnt   (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        exp_valid = 1'b0;
  logic [16:0] exp_vec;
  logic        exp_tmo;
  int          exp_cyc, exp_ret;

  logic tmo_m = 1'b0;
  int   cyc_m = 0, ret_m = 0, wait_k = 0;

  logic [31:0] ir_h, pc_h, rw_h, mw_h, il_h;

  logic [16:0] dut_vec;
  assign dut_vec = {mem_valid, adr_src, ir_write, pc_write, mem_write, reg_write,
                    result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_op};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] pack(input logic mv, as, irw, pcw, mw, rw,
                                       input logic [1:0] rs, sa, sb, aop, im,
                                       input logic ill);
    return {mv, as, irw, pcw, mw, rw, rs, sa, sb, aop, im, ill};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == OP_ST)  return 2'b01;
    if (op == OP_BEQ) return 2'b10;
    if (op == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic legal(input logic [6:0] op);
    return op == OP_LD || op == OP_ST || op == OP_R || op == OP_I || op == OP_BEQ || op == OP_JAL;
  endfunction

  // Output table per instruction step, straight from the control-signal description
  function automatic logic [16:0] expect_out(input step_t st, input logic rdy, input logic z,
                                             input logic [6:0] op);
    logic [1:0] im;
    im = imm_of(op);
    case (st)
      S_F:     return pack(1, 0, rdy, rdy, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, im, 0);
      S_D:     return pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, im, !legal(op));
      S_MA:    return pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, im, 0);
      S_MR:    return pack(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 0);
      S_MWB:   return pack(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, im, 0);
      S_MW:    return pack(1, 1, 0, 0, rdy, 0, 2'b00, 2'b00, 2'b00, 2'b00, im, 0);
      S_XR:    return pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, im, 0);
      S_XI:    return pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, im, 0);
      S_AWB:   return pack(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, im, 0);
      S_BEQ:   return pack(0, 0, 0, z, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, im, 0);
      S_JAL:   return pack(0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, im, 0);
      default: return 17'd0;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      chk("ctrl_outs", 32'(dut_vec), 32'(exp_vec));
      chk("mem_timeout", 32'(mem_timeout), 32'(exp_tmo));
`ifdef MC_CTRL_PERF_EN
      chk("cycle_cnt", 32'(cycle_cnt), 32'(exp_cyc));
      chk("retired_cnt", 32'(retired_cnt), 32'(exp_ret));
`endif
    end
  end

  task automatic clr_hist();
    ir_h = 0; pc_h = 0; rw_h = 0; mw_h = 0; il_h = 0;
  endtask

  task automatic cyc(input step_t st, input logic rdy, input logic z, input logic retire);
    @(negedge clk);
    rst_n     = rst_next;
    mem_ready = rdy;
    zero      = z;
    exp_vec   = expect_out(st, rdy, z, opcode);
    exp_tmo   = tmo_m;
    exp_cyc   = cyc_m % (1 << CW);
    exp_ret   = ret_m % (1 << CW);
    exp_valid = 1'b1;
    #3;
    ir_h = {ir_h[30:0], ir_write};
    pc_h = {pc_h[30:0], pc_write};
    rw_h = {rw_h[30:0], reg_write};
    mw_h = {mw_h[30:0], mem_write};
    il_h = {il_h[30:0], illegal_op};
    if (st == S_RST) begin
      tmo_m = 0; cyc_m = 0; ret_m = 0; wait_k = 0;
    end else begin
      cyc_m++;
      if ((st == S_F || st == S_MR || st == S_MW) && !rdy) begin
        wait_k++;
        if (TO != 0 && wait_k >= TO) tmo_m = 1'b1;
      end else begin
        wait_k = 0;
      end
      if (retire) ret_m++;
    end
  endtask

  task automatic do_reset(input int low_cycles);
    rst_n = 1'b0;
    rst_next = 1'b0;
    tmo_m = 0; cyc_m = 0; ret_m = 0; wait_k = 0;
    for (int i = 0; i < low_cycles; i++) cyc(S_RST, rbit(), rbit(), 0);
    rst_next = 1'b1;
    cyc(S_RST, rbit(), rbit(), 0);
  endtask

  task automatic mem_step(input step_t st, input int waits, input logic retire);
    for (int i = 0; i < waits; i++) cyc(st, 1'b0, rbit(), 0);
    cyc(st, 1'b1, rbit(), retire);
  endtask

  task automatic run_instr(input logic [6:0] op, input int wf, input int wm, input logic z);
    mem_step(S_F, wf, 0);
    opcode = op;
    cyc(S_D, rbit(), rbit(), 0);
    case (op)
      OP_LD: begin
        cyc(S_MA, rbit(), rbit(), 0);
        mem_step(S_MR, wm, 0);
        cyc(S_MWB, rbit(), rbit(), 1);
      end
      OP_ST: begin
        cyc(S_MA, rbit(), rbit(), 0);
        mem_step(S_MW, wm, 1);
      end
      OP_R: begin
        cyc(S_XR, rbit(), rbit(), 0);
        cyc(S_AWB, rbit(), rbit(), 1);
      end
      OP_I: begin
        cyc(S_XI, rbit(), rbit(), 0);
        cyc(S_AWB, rbit(), rbit(), 1);
      end
      OP_BEQ: cyc(S_BEQ, rbit(), z, 1);
      OP_JAL: begin
        cyc(S_JAL, rbit(), rbit(), 0);
        cyc(S_AWB, rbit(), rbit(), 1);
      end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [6:0] op;
    int         kind, wf, wm;

    do_reset(2);

    clr_hist();
    run_instr(OP_R, 0, 0, 0);
    chk("rtype_ir_write_cycles", ir_h[3:0], 32'b1000);
    chk("rtype_reg_write_cycles", rw_h[3:0], 32'b0001);
`ifdef MC_CTRL_PERF_EN
    chk("rtype_retired", 32'(retired_cnt), 32'd1);
`endif

    clr_hist();
    run_instr(OP_LD, 0, 3, 0);
    chk("load_8cycle_ir", ir_h[7:0], 32'b1000_0000);
    chk("load_8cycle_rw", rw_h[7:0], 32'b0000_0001);
    chk("load_3wait_no_timeout", 32'(mem_timeout), 32'd0);

    clr_hist();
    run_instr(OP_BEQ, 0, 0, 1'b1);
    chk("beq_taken_pc_write", pc_h[2:0], 32'b101);
    clr_hist();
    run_instr(OP_BEQ, 0, 0, 1'b0);
    chk("beq_not_taken_pc_write", pc_h[2:0], 32'b100);

    clr_hist();
    run_instr(7'b1111111, 0, 0, 0);
    chk("illegal_pulse", il_h[1:0], 32'b01);
    chk("illegal_no_writes", rw_h[1:0] | mw_h[1:0], 32'd0);
`ifdef MC_CTRL_PERF_EN
    chk("illegal_retired_unchanged", 32'(retired_cnt), 32'd4);
`endif

    run_instr(OP_R, 4, 0, 0);
    chk("timeout_sticky", 32'(mem_timeout), 32'd1);

    // Reset asserted while a store is stalled
    clr_hist();
    mem_step(S_F, 0, 0);
    opcode = OP_ST;
    cyc(S_D, rbit(), rbit(), 0);
    cyc(S_MA, rbit(), rbit(), 0);
    cyc(S_MW, 1'b0, rbit(), 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("async_rst_timeout_clear", 32'(mem_timeout), 32'd0);
    do_reset(2);
    chk("store_reset_no_strobe", mw_h[7:0], 32'd0);
    run_instr(OP_JAL, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      if (n % 50 == 49) do_reset(1 + $urandom_range(0, 1));
      kind = $urandom_range(0, 7);
      case (kind)
        0: op = OP_LD;
        1: op = OP_ST;
        2, 7: op = OP_R;
        3: op = OP_I;
        4: op = OP_BEQ;
        5: op = OP_JAL;
        default: begin
          op = 7'($urandom);
          if (legal(op)) op = 7'h7f;
        end
      endcase
      wf = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
      wm = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
      run_instr(op, wf, wm, rbit());
    end

    @(negedge clk);
    exp_valid = 1'b0;
    #5;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multi-cycle RV32I core: walks each instruction through fetch, decode, execute, memory and writeback steps, and drives the shared-ALU/shared-memory datapath selects and write strobes every cycle. It replaces the single-cycle main decoder in the multi-cycle build. It sits between the instruction register's opcode field and the datapath muxes. It stalls on a memory-ready handshake and flags memory timeouts.

## Interface
- MEM_TIMEOUT, 255: cycles a memory access may wait for `mem_ready` before `mem_timeout` sets; 0 disables the check.
- CNT_W, 32: width of performance counters (only with `MC_CTRL_PERF_EN`).
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  7  `instr[6:0]` from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access.
- mem_valid  out  1  memory access request.
- adr_src  out  1  0 = PC, 1 = Result.
- ir_write  out  1  load instruction register.
- pc_write  out  1  load PC.
- mem_write  out  1  store strobe.
- reg_write  out  1  register file write.
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RD1.
- alu_src_b  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded.
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J; decoded from `opcode` in every state.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- mem_timeout  out  1  sticky until reset.
- retired_cnt, cycle_cnt  out  CNT_W  only with `MC_CTRL_PERF_EN`.

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Every output not listed for a state is 0.
- RESET:
  - All outputs are 0.
  - Next state is FETCH.
- FETCH:
  - Drives mem_valid=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10.
  - When `mem_ready` is 1: ir_write=1 and pc_write=1, then go to DECODE.
  - Otherwise hold in FETCH with both strobes at 0.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01 (computes the branch target).
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL.
  - Any other opcode: pulse illegal_op and go to FETCH.
- MEMADR:
  - Drives alu_src_a=10, alu_src_b=01.
  - Next state is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD:
  - Drives mem_valid=1, adr_src=1.
  - Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1; next state FETCH.
- MEMWRITE:
  - Drives mem_valid=1, adr_src=1.
  - mem_write = mem_ready, so exactly one strobe cycle; goes to FETCH on `mem_ready`.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10; next state ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10; next state ALUWB.
- ALUWB: result_src=00, reg_write=1; next state FETCH.
- BEQ:
  - Drives alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero (combinational); next state FETCH.
- JAL:
  - Drives alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1.
  - Next state ALUWB, which writes PC+4 to rd.
- Timeout counter:
  - Clears on every entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each waiting cycle with `mem_ready`=0.
  - Reaching MEM_TIMEOUT sets mem_timeout; the FSM keeps waiting.

## Timing
- The state register is the only sequential control; all outputs decode combinationally from state (plus `mem_ready` / `zero` where noted).
- Minimum cycle counts with zero wait states:
  - R/I/JAL: 4
  - load: 5
  - store: 4
  - beq: 3
- Each memory wait cycle adds exactly one cycle to the instruction.
- Reset:
  - Asserting `rst_n` at any cycle, including mid-access, forces RESET asynchronously.
  - All outputs are 0 and mem_timeout clears.
  - The first FETCH occurs in the cycle after RESET.
- `mem_ready` is ignored in every state except FETCH, MEMREAD and MEMWRITE.
- `zero` is ignored outside BEQ.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - cycle_cnt increments every non-RESET cycle.
  - retired_cnt increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ; the illegal-opcode path does not count.
  - Both counters wrap at 2^CNT_W and clear on reset.
- Undefined: both ports and their logic are absent.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - opcode localparams;
  - encoding localparams for result_src, alu_src_a, alu_src_b, alu_op and imm_src.
- Sub-module `mc_imm_decoder` maps opcode → imm_src combinationally.

## Test plan
- R-type add (opcode 0110011), mem_ready=1 throughout → states FETCH, DECODE, EXECR, ALUWB; reg_write high only in cycle 4; retired_cnt=1.
- Load (0000011) with mem_ready low for 3 cycles in MEMREAD → 8 cycles total; reg_write with result_src=01 in the final cycle.
- beq (1100011):
  - zero=1 → pc_write=1 in BEQ.
  - zero=0 → pc_write=0.
  - Either way, back to FETCH next cycle.
- Opcode 1111111 → illegal_op pulses 1 cycle in DECODE; reg_write and mem_write stay 0; retired_cnt unchanged.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → mem_timeout rises after the 4th wait cycle and stays high after mem_ready returns.
- rst_n pulsed low in MEMWRITE before mem_ready → mem_write never strobes; outputs 0; FETCH resumes one cycle after release.
